// File: rtl/imem_fetch.sv
// Instruction memory with a valid/ready fetch port, a program-load write port
// and a flush that discards a held response on a pipeline redirect.
module imem_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              resp_ready,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    // Handshake: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready. flush
    // drops a held response. A new request is taken only when the slot is
    // free or being vacated on the same edge, and never while loading.

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic              accept;
    logic              req_in_range;
    logic              load_in_range;

    assign req_in_range  = ({1'b0, req_addr} < DEPTH_W);
    assign load_in_range = ({1'b0, load_addr} < DEPTH_W);

    assign req_ready = !load_en && (!resp_valid_q || resp_ready || flush);
    assign accept    = req_valid && req_ready;

    // Storage is not reset so a program survives a mid-stream reset.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            if (req_in_range) begin
                resp_data_d = mem[req_addr];
                resp_err_d  = 1'b0;
            end else begin
                resp_data_d = '0;
                resp_err_d  = 1'b1;
            end
        end else if (resp_valid_q && (resp_ready || flush)) begin
            resp_valid_d = 1'b0;
            resp_data_d  = '0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed scenarios plus a randomized run, checked
// against a queue-based response model of the fetch port.
module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic [4:0]  req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        resp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    logic        b_req_valid = 1'b0;
    logic [4:0]  b_req_addr = '0;
    logic        b_req_ready;
    logic        b_resp_valid;
    logic [31:0] b_resp_data;
    logic        b_resp_err;
    logic        b_resp_ready = 1'b1;
    logic        b_flush = 1'b0;
    logic        b_load_en = 1'b0;
    logic [4:0]  b_load_addr = '0;
    logic [31:0] b_load_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [32];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    imem_fetch #(.DATA_W(32), .ADDR_W(5), .DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .resp_ready(resp_ready), .flush(flush),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_fetch #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) dut20 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
        .resp_ready(b_resp_ready), .flush(b_flush),
        .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data)
    );

    // Effect of the coming edge on the expected response stream of dut.
    task automatic model_edge();
        bit acc;
        acc = req_valid && !load_en && (exp_q.size() == 0 || resp_ready || flush);
        if (exp_q.size() != 0 && (resp_ready || flush)) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({1'b0, mem_m[req_addr]});
        if (load_en) mem_m[load_addr] = load_data;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0; load_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b d=%h e=%b, want 0/0/0", resp_valid, resp_data, resp_err);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_req_ready: got %b, want 1", req_ready);
        end
        load_en = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_load_blocks: got %b, want 0", req_ready);
        end
        load_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 32; i++) begin
            load_en = 1'b1; load_addr = 5'(i); load_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        load_en = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 34; i++) begin
            req_valid = (i < 32);
            req_addr = 5'(i);
            #1;
            if (i < 32) begin
                n_cmp++;
                if (req_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL stream_ready[%0d]: got %b, want 1", i, req_ready);
                end
            end
            n_cmp++;
            if (i == 0 || i == 33) begin
                if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin
                    n_bad++;
                    $display("FAIL stream_idle[%0d]: got v=%b d=%h, want 0/0", i, resp_valid, resp_data);
                end
            end else if (resp_valid !== 1'b1 || resp_err !== 1'b0 ||
                         resp_data !== 32'h1000_0000 + 32'(i - 1)) begin
                n_bad++;
                $display("FAIL stream_resp[%0d]: got v=%b d=%h e=%b, want 1/%h/0",
                         i, resp_valid, resp_data, resp_err, 32'h1000_0000 + 32'(i - 1));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_back_pressure();
        req_valid = 1'b1; req_addr = 5'd3; resp_ready = 1'b1;
        tick();
        req_addr = 5'd4; resp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0003 || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold[%0d]: got v=%b d=%h rdy=%b, want 1/10000003/0",
                         c, resp_valid, resp_data, req_ready);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_release_ready: got %b, want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0004) begin
            n_bad++;
            $display("FAIL hold_next: got v=%b d=%h, want 1/10000004", resp_valid, resp_data);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL hold_drain: got v=%b d=%h, want 0/0", resp_valid, resp_data);
        end
        idle();
    endtask

    task automatic test_flush();
        req_valid = 1'b1; req_addr = 5'd7; resp_ready = 1'b0;
        tick();
        req_addr = 5'd9; flush = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_data !== 32'h1000_0007) begin
            n_bad++;
            $display("FAIL flush_ready: got rdy=%b d=%h, want 1/10000007", req_ready, resp_data);
        end
        tick();
        req_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0009) begin
            n_bad++;
            $display("FAIL flush_new: got v=%b d=%h, want 1/10000009", resp_valid, resp_data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0; flush = 1'b1;
        tick();
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_alone: got v=%b d=%h e=%b, want 0/0/0", resp_valid, resp_data, resp_err);
        end
        idle();
    endtask

    task automatic test_load_priority();
        // A held response must still drain while a load blocks new requests.
        req_valid = 1'b1; req_addr = 5'd6;
        tick();
        load_en = 1'b1; load_addr = 5'd2; load_data = 32'hDEAD_BEEF;
        req_addr = 5'd2; resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL load_blocks_req: got %b, want 0", req_ready);
        end
        tick();
        load_en = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load_drain: got v=%b, want 0", resp_valid);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL read_after_load: got v=%b d=%h, want 1/deadbeef", resp_valid, resp_data);
        end
        tick();
        idle();
    endtask

    task automatic test_depth20();
        b_load_en = 1'b1; b_load_addr = 5'd5; b_load_data = 32'h0000_5555;
        @(posedge clk); #1;
        b_load_addr = 5'd25; b_load_data = 32'h0000_0BAD;
        @(posedge clk); #1;
        b_load_en = 1'b0; b_req_valid = 1'b1; b_req_addr = 5'd25;
        @(posedge clk); #1;
        n_cmp++;
        if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b1 || b_resp_data !== 32'h0) begin
            n_bad++;
            $display("FAIL oob_err: got v=%b d=%h e=%b, want 1/0/1", b_resp_valid, b_resp_data, b_resp_err);
        end
        b_req_addr = 5'd5;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n_cmp++;
        if (b_resp_valid !== 1'b1 || b_resp_err !== 1'b0 || b_resp_data !== 32'h0000_5555) begin
            n_bad++;
            $display("FAIL oob_load_ignored: got v=%b d=%h e=%b, want 1/5555/0", b_resp_valid, b_resp_data, b_resp_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 5'd10;
        tick();
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b d=%h e=%b, want 0/0/0", resp_valid, resp_data, resp_err);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b1; req_addr = 5'd1; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h1000_0001) begin
            n_bad++;
            $display("FAIL mem_kept: got v=%b d=%h, want 1/10000001", resp_valid, resp_data);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [32:0] exp_r;
        bit exp_rdy;
        for (int c = 0; c < 400; c++) begin
            load_en    = ($urandom_range(0, 7) == 0);
            load_addr  = 5'($urandom_range(0, 31));
            load_data  = $urandom;
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr   = 5'($urandom_range(0, 31));
            resp_ready = ($urandom_range(0, 1) == 1);
            flush      = ($urandom_range(0, 7) == 0);
            #1;
            exp_rdy = !load_en && (exp_q.size() == 0 || resp_ready || flush);
            exp_r = (exp_q.size() != 0) ? exp_q[0] : 33'h0;
            n_cmp++;
            if (req_ready !== exp_rdy || resp_valid !== (exp_q.size() != 0) ||
                {resp_err, resp_data} !== exp_r) begin
                n_bad++;
                $display("FAIL random[%0d]: got rdy=%b v=%b e=%b d=%h, want rdy=%b v=%b e=%b d=%h",
                         c, req_ready, resp_valid, resp_err, resp_data,
                         exp_rdy, exp_q.size() != 0, exp_r[32], exp_r[31:0]);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_load_priority();
        test_depth20();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised single-port instruction memory with a valid/ready fetch interface, a program-load write port and a pipeline flush input. Sits between the fetch stage and the instruction store: the fetch stage issues word addresses, receives one registered instruction word per accepted request, and may stall or redirect. Replaces the fixed 32×32 enable-only instruction memory.

## Interface
- DATA_W, 32, instruction word width in bits
- ADDR_W, 5, word-address width
- DEPTH, 32, number of implemented words; 1 ≤ DEPTH ≤ 2**ADDR_W
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  fetch request present
- req_addr  input  ADDR_W  word address of request
- req_ready  output  1  request accepted this cycle when req_valid && req_ready
- resp_valid  output  1  resp_data/resp_err hold a response
- resp_data  output  DATA_W  fetched instruction word
- resp_err  output  1  request address was ≥ DEPTH
- resp_ready  input  1  consumer takes response this cycle
- flush  input  1  discard any held response (redirect)
- load_en  input  1  write load_data into memory this cycle
- load_addr  input  ADDR_W  word address for load write
- load_data  input  DATA_W  word to write

## Operation
- Storage: DEPTH × DATA_W array; contents not reset; undefined until loaded.
- Load: on edge with load_en=1 and load_addr < DEPTH, mem[load_addr] ← load_data. load_addr ≥ DEPTH ignored (no error output).
- req_ready = !load_en && (!resp_valid || resp_ready || flush). Combinational; load always has priority over fetch.
- Accept (req_valid && req_ready): next edge sets resp_valid=1; if req_addr < DEPTH, resp_data ← mem[req_addr], resp_err ← 0; else resp_data ← 0, resp_err ← 1.
- Hold: resp_valid && !resp_ready && !flush → resp_valid, resp_data, resp_err unchanged.
- Drain: resp_valid && (resp_ready || flush) with no accept → resp_valid ← 0, resp_data ← 0, resp_err ← 0.
- Flush with simultaneous accept: old response discarded, new request's response registered normally (flush kills only the held response, never the request accepted on the same edge).
- Flush with resp_valid=0 and no accept: no effect.
- Read-after-load: a load on edge N followed by accept of same address on edge N+1 returns the newly written word.
- resp_data and resp_err are 0 whenever resp_valid=0 (no tri-state output).

## Timing
- Reset (async assert, sync-free release): resp_valid=0, resp_data=0, resp_err=0 immediately; req_ready follows its equation (=!load_en after reset).
- Latency: request accepted at edge N → resp_valid=1 visible after edge N (one cycle).
- Throughput: one request per cycle when resp_ready held 1 and load_en=0.
- Back-pressure: resp_ready=0 with resp_valid=1 forces req_ready=0 the same cycle; no request is lost or duplicated.
- load_en=1 forces req_ready=0 regardless of other inputs; a held response still drains via resp_ready/flush during load.
- Reset mid-stream: any held response lost; memory contents preserved.

## Test plan
- Load mem[0..31] = 0x1000_0000+i, then stream req_addr 0..31 with resp_ready=1 → 32 responses, back-to-back, resp_data = 0x1000_0000+addr, resp_err=0, first one cycle after first accept.
- Accept addr 3, hold resp_ready=0 for 4 cycles → resp_valid=1, resp_data=0x1000_0003 stable, req_ready=0 throughout; raise resp_ready with req addr 4 pending → addr 4 accepted same cycle, 0x1000_0004 next cycle.
- DEPTH=20: request addr 25 → resp_err=1, resp_data=0; load to addr 25 leaves addr 5 unchanged.
- Held response for addr 7, assert flush with req addr 9 → response for 7 never consumed, next cycle resp_data=0x1000_0009; flush alone with nothing held → no response.
- load_en=1 with req_valid=1 → req_ready=0; load addr 2 = 0xDEAD_BEEF, next cycle fetch addr 2 → 0xDEAD_BEEF.
- Assert rst while resp_valid=1 → outputs 0 without a clock edge; after release fetch addr 1 returns pre-reset loaded value.
